// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_master
//  Purpose  : Single-master I2C byte engine. Generates SCL and executes
//             START / repeated START, WRITE byte, READ byte and STOP commands
//             issued by a local controller. SDA is open-drain.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_master #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCL_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic [7:0] tx_data,
    input  logic       ack_in,
    output logic [7:0] rx_data,
    output logic       ack_out,
    output logic       ready,
    output logic       done,
    output logic       busy,
    output logic       scl,
    inout  wire        sda
);

    // Quarter SCL period in system clocks; every bus phase lasts this long.
    localparam int              c_Q      = CLK_FREQ / (4 * SCL_FREQ);
    localparam int              c_QW     = (c_Q > 1) ? $clog2(c_Q) : 1;
    localparam logic [c_QW-1:0] c_Q_LAST = c_QW'(c_Q - 1);
    localparam logic [c_QW-1:0] c_Q_ONE  = c_QW'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HOLD   = 4'd1,
        S_START  = 4'd2,
        S_RSTART = 4'd3,
        S_WBIT   = 4'd4,
        S_WACK   = 4'd5,
        S_RBIT   = 4'd6,
        S_RACK   = 4'd7,
        S_STOP   = 4'd8
    } state_t;

    state_t          r_state,     w_state_nx;
    logic [c_QW-1:0] r_qcnt,      w_qcnt_nx;
    logic [1:0]      r_phase,     w_phase_nx;
    logic [2:0]      r_bit,       w_bit_nx;
    logic [7:0]      r_tx,        w_tx_nx;
    logic [7:0]      r_rx_sh,     w_rx_sh_nx;
    logic            r_ack_lat,   w_ack_lat_nx;
    logic            r_ack_smp,   w_ack_smp_nx;
    logic            r_ack_out,   w_ack_out_nx;
    logic [7:0]      r_rx_data,   w_rx_data_nx;
    logic            r_done,      w_done_nx;
    logic            r_scl,       w_scl_nx;
    logic            r_sda_low,   w_sda_low_nx;

    logic            w_sda_in;
    logic            w_phase_end;
    logic            w_sample;
    logic            w_slot_end;

    // SDA is only sampled mid-high of SCL, where the slave holds it stable.
    assign w_sda_in = sda;

    // State, counters, datapath and registered bus drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_phase   <= 2'd0;
            r_bit     <= 3'd0;
            r_tx      <= 8'h00;
            r_rx_sh   <= 8'h00;
            r_ack_lat <= 1'b0;
            r_ack_smp <= 1'b0;
            r_ack_out <= 1'b0;
            r_rx_data <= 8'h00;
            r_done    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_qcnt    <= w_qcnt_nx;
            r_phase   <= w_phase_nx;
            r_bit     <= w_bit_nx;
            r_tx      <= w_tx_nx;
            r_rx_sh   <= w_rx_sh_nx;
            r_ack_lat <= w_ack_lat_nx;
            r_ack_smp <= w_ack_smp_nx;
            r_ack_out <= w_ack_out_nx;
            r_rx_data <= w_rx_data_nx;
            r_done    <= w_done_nx;
            r_scl     <= w_scl_nx;
            r_sda_low <= w_sda_low_nx;
        end
    end

    // Next-state, datapath updates and the SCL/SDA levels for the next cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_qcnt_nx    = r_qcnt;
        w_phase_nx   = r_phase;
        w_bit_nx     = r_bit;
        w_tx_nx      = r_tx;
        w_rx_sh_nx   = r_rx_sh;
        w_ack_lat_nx = r_ack_lat;
        w_ack_smp_nx = r_ack_smp;
        w_ack_out_nx = r_ack_out;
        w_rx_data_nx = r_rx_data;
        w_done_nx    = 1'b0;
        w_scl_nx     = 1'b1;
        w_sda_low_nx = r_sda_low;

        w_phase_end  = (r_qcnt == c_Q_LAST);
        w_sample     = w_phase_end && (r_phase == 2'd1);
        w_slot_end   = w_phase_end && (r_phase == 2'd3);

        case (r_state)
            S_IDLE: begin
                // Without bus ownership only a START makes sense.
                if (cmd_start) begin
                    w_state_nx = S_START;
                    w_qcnt_nx  = '0;
                    w_phase_nx = 2'd0;
                end
            end
            S_HOLD: begin
                w_qcnt_nx  = '0;
                w_phase_nx = 2'd0;
                if (cmd_start) begin
                    w_state_nx = S_RSTART;
                end else if (cmd_stop) begin
                    w_state_nx = S_STOP;
                end else if (cmd_write) begin
                    w_state_nx = S_WBIT;
                    w_bit_nx   = 3'd0;
                    w_tx_nx    = tx_data;
                end else if (cmd_read) begin
                    w_state_nx   = S_RBIT;
                    w_bit_nx     = 3'd0;
                    w_ack_lat_nx = ack_in;
                end
            end
            default: begin
                if (w_phase_end) begin
                    w_qcnt_nx  = '0;
                    w_phase_nx = r_phase + 2'd1;
                end else begin
                    w_qcnt_nx  = r_qcnt + c_Q_ONE;
                end

                if (w_sample && (r_state == S_RBIT)) begin
                    w_rx_sh_nx = {r_rx_sh[6:0], w_sda_in};
                end
                if (w_sample && (r_state == S_WACK)) begin
                    w_ack_smp_nx = w_sda_in;
                end

                if (w_slot_end) begin
                    case (r_state)
                        S_START, S_RSTART: begin
                            w_state_nx = S_HOLD;
                            w_done_nx  = 1'b1;
                        end
                        S_STOP: begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                        end
                        S_WBIT: begin
                            if (r_bit == 3'd7) w_state_nx = S_WACK;
                            else               w_bit_nx   = r_bit + 3'd1;
                        end
                        S_RBIT: begin
                            if (r_bit == 3'd7) w_state_nx = S_RACK;
                            else               w_bit_nx   = r_bit + 3'd1;
                        end
                        S_WACK: begin
                            w_state_nx   = S_HOLD;
                            w_done_nx    = 1'b1;
                            w_ack_out_nx = r_ack_smp;
                        end
                        S_RACK: begin
                            w_state_nx   = S_HOLD;
                            w_done_nx    = 1'b1;
                            w_rx_data_nx = r_rx_sh;
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        // Bus levels follow the upcoming state/phase so they change in step
        // with the phase counter rather than one cycle behind it.
        case (w_state_nx)
            S_IDLE: begin
                w_scl_nx     = 1'b1;
                w_sda_low_nx = 1'b0;
            end
            S_HOLD: begin
                w_scl_nx = 1'b0;
            end
            S_START: begin
                w_scl_nx = (w_phase_nx != 2'd3);
                if (w_phase_nx == 2'd0)      w_sda_low_nx = 1'b0;
                else if (w_phase_nx != 2'd3) w_sda_low_nx = 1'b1;
            end
            S_RSTART: begin
                w_scl_nx = (w_phase_nx == 2'd1) || (w_phase_nx == 2'd2);
                if (w_phase_nx == 2'd0)      w_sda_low_nx = 1'b0;
                else if (w_phase_nx == 2'd2) w_sda_low_nx = 1'b1;
            end
            S_STOP: begin
                w_scl_nx     = (w_phase_nx != 2'd0);
                w_sda_low_nx = (w_phase_nx <= 2'd1);
            end
            default: begin
                // Bit slots: SDA only moves in P0 while SCL is low.
                w_scl_nx = (w_phase_nx == 2'd1) || (w_phase_nx == 2'd2);
                if (w_phase_nx == 2'd0) begin
                    if (w_state_nx == S_WBIT)      w_sda_low_nx = ~w_tx_nx[3'd7 - w_bit_nx];
                    else if (w_state_nx == S_RACK) w_sda_low_nx = ~w_ack_lat_nx;
                    else                           w_sda_low_nx = 1'b0;
                end
            end
        endcase
    end

    assign sda     = r_sda_low ? 1'b0 : 1'bz;
    assign scl     = r_scl;
    assign done    = r_done;
    assign ack_out = r_ack_out;
    assign rx_data = r_rx_data;
    assign ready   = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign busy    = (r_state != S_IDLE) && (r_state != S_START);

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_master
//  Purpose  : Directed self-checking bench for i2c_master with a behavioural
//             I2C slave at 7-bit address 0x00 (address, word address, data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master;

    localparam int CLK_FREQ = 4_000_000;
    localparam int SCL_FREQ = 100_000;
    localparam int Q        = CLK_FREQ / (4 * SCL_FREQ);
    localparam int OP_START = 0;
    localparam int OP_STOP  = 1;
    localparam int OP_WRITE = 2;
    localparam int OP_READ  = 3;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       cmd_start = 1'b0;
    logic       cmd_write = 1'b0;
    logic       cmd_read  = 1'b0;
    logic       cmd_stop  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       ack_in    = 1'b0;
    logic [7:0] rx_data;
    logic       ack_out;
    logic       ready;
    logic       done;
    logic       busy;
    logic       scl;
    wire        sda_bus;

    logic       s_drive = 1'b0;
    pullup (sda_bus);
    assign sda_bus = s_drive ? 1'b0 : 1'bz;

    i2c_master #(
        .CLK_FREQ (CLK_FREQ),
        .SCL_FREQ (SCL_FREQ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_start (cmd_start),
        .cmd_write (cmd_write),
        .cmd_read  (cmd_read),
        .cmd_stop  (cmd_stop),
        .tx_data   (tx_data),
        .ack_in    (ack_in),
        .rx_data   (rx_data),
        .ack_out   (ack_out),
        .ready     (ready),
        .done      (done),
        .busy      (busy),
        .scl       (scl),
        .sda       (sda_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural slave: address 0x00, byte 2 is the register pointer,
    // later bytes are written to consecutive registers. A read address
    // keeps the read direction across a repeated START; it then sends
    // s_tx MSB first until the master NACKs.
    // ------------------------------------------------------------------
    logic       s_active = 1'b0;
    logic       s_sel    = 1'b0;
    logic       s_rd     = 1'b0;
    logic       s_send   = 1'b0;
    logic       s_mack   = 1'b0;
    int         s_bits   = 0;
    int         s_idx    = 0;
    logic [7:0] s_sh     = 8'h00;
    logic [7:0] s_mon    = 8'h00;
    logic [7:0] s_ptr    = 8'h00;
    logic [7:0] s_tx     = 8'h3C;
    logic [7:0] s_regs [0:15];
    int         n_start  = 0;
    int         n_stop   = 0;
    int         n_rise   = 0;
    logic       p_scl    = 1'b1;
    logic       p_sda    = 1'b1;

    // Bus watcher: START/STOP detection, bit sampling and slave responses.
    always @(scl or sda_bus) begin
        if (p_scl && scl && p_sda && !sda_bus) begin
            n_start++;
            s_active = 1'b1;
            s_bits   = 0;
            s_mack   = 1'b0;
            if (s_rd) begin
                s_send = 1'b1;
            end else begin
                s_send = 1'b0;
                s_idx  = 0;
                s_sel  = 1'b0;
            end
        end else if (p_scl && scl && !p_sda && sda_bus) begin
            n_stop++;
            s_active = 1'b0;
            s_rd     = 1'b0;
            s_send   = 1'b0;
            s_drive  = 1'b0;
            s_bits   = 0;
        end else if (!p_scl && scl) begin
            n_rise++;
            if (s_active) begin
                if (s_bits < 8) begin
                    s_sh  = {s_sh[6:0], sda_bus};
                    s_mon = {s_mon[6:0], sda_bus};
                end else if (s_bits == 8 && s_send) begin
                    s_mack = sda_bus;
                end
                s_bits++;
            end
        end else if (p_scl && !scl) begin
            if (s_active) begin
                s_drive = 1'b0;
                if (s_bits >= 9) begin
                    s_bits = 0;
                    if (s_send && s_mack) s_send = 1'b0;
                end
                if (s_send) begin
                    if (s_bits < 8) s_drive = !s_tx[3'(7 - s_bits)];
                end else if (s_bits == 8) begin
                    case (s_idx)
                        0: begin
                            s_sel = (s_sh[7:1] == 7'h00);
                            s_rd  = s_sel && s_sh[0];
                            s_idx = 1;
                        end
                        1: begin
                            s_ptr = s_sh;
                            s_idx = 2;
                        end
                        default: begin
                            if (s_sel) s_regs[s_ptr[3:0]] = s_sh;
                            s_ptr = s_ptr + 8'd1;
                        end
                    endcase
                    s_drive = s_sel;
                end
            end
        end
        p_scl = scl;
        p_sda = sda_bus;
    end

    // ------------------------------------------------------------------
    int   n_vec     = 0;
    int   n_err     = 0;
    logic rdy_after = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command pulse and return the acceptance-to-done latency
    // in clocks (-1 if done never arrives).
    task automatic issue(input int op, input logic [7:0] d, input logic a, output int lat);
        int t0;
        @(posedge clk); #1;
        tx_data   = d;
        ack_in    = a;
        cmd_start = (op == OP_START);
        cmd_stop  = (op == OP_STOP);
        cmd_write = (op == OP_WRITE);
        cmd_read  = (op == OP_READ);
        t0 = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        cmd_write = 1'b0;
        cmd_read  = 1'b0;
        rdy_after = ready;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   r0;
        logic dseen;
        logic rlow;

        // --- reset state ---
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl",     32'(scl),     32'd1);
        check("rst_sda",     32'(sda_bus), 32'd1);
        check("rst_ready",   32'(ready),   32'd1);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_ack_out", 32'(ack_out), 32'd0);
        reset = 1'b0;

        // --- write/read/stop in IDLE are ignored ---
        r0 = n_rise;
        @(posedge clk); #1;
        cmd_write = 1'b1; cmd_read = 1'b1; cmd_stop = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1;
        cmd_read = 1'b0; cmd_stop = 1'b0;
        @(posedge clk); #1;
        cmd_write = 1'b0;
        dseen = 1'b0;
        rlow  = 1'b0;
        repeat (20) begin
            if (done)   dseen = 1'b1;
            if (!ready) rlow  = 1'b1;
            @(posedge clk); #1;
        end
        check("idle_no_done", 32'(dseen),  32'd0);
        check("idle_ready",   32'(rlow),   32'd0);
        check("idle_no_scl",  n_rise - r0, 32'd0);
        check("idle_busy",    32'(busy),   32'd0);

        // --- START + write address 0x00 ---
        r0 = n_start;
        issue(OP_START, 8'h00, 1'b0, lat);
        check("start_lat",   lat,            4 * Q + 1);
        check("start_cond",  n_start - r0,   32'd1);
        check("start_ready", 32'(rdy_after), 32'd0);
        check("start_busy",  32'(busy),      32'd1);
        check("start_scl",   32'(scl),       32'd0);
        r0 = n_rise;
        issue(OP_WRITE, 8'h00, 1'b0, lat);
        check("wr0_lat",   lat,         36 * Q + 1);
        check("wr0_rises", n_rise - r0, 32'd9);
        check("wr0_ack",   32'(ack_out), 32'd0);

        // --- pointer 0x01, data 0xA5, STOP ---
        issue(OP_WRITE, 8'h01, 1'b0, lat);
        check("wr1_ack", 32'(ack_out), 32'd0);
        issue(OP_WRITE, 8'hA5, 1'b0, lat);
        check("wr2_ack", 32'(ack_out), 32'd0);
        r0 = n_stop;
        issue(OP_STOP, 8'h00, 1'b0, lat);
        check("stop_lat",  lat,          4 * Q + 1);
        check("stop_cond", n_stop - r0,  32'd1);
        check("stop_busy", 32'(busy),    32'd0);
        check("stop_scl",  32'(scl),     32'd1);
        check("stop_sda",  32'(sda_bus), 32'd1);
        check("slave_reg1", 32'(s_regs[1]), 32'hA5);

        // --- absent device at 0x28 ---
        issue(OP_START, 8'h00, 1'b0, lat);
        issue(OP_WRITE, 8'h50, 1'b0, lat);
        check("nodev_lat",  lat,          36 * Q + 1);
        check("nodev_ack",  32'(ack_out), 32'd1);
        check("nodev_busy", 32'(busy),    32'd1);
        issue(OP_STOP, 8'h00, 1'b0, lat);
        check("nodev_stop_lat",  lat,       4 * Q + 1);
        check("nodev_stop_busy", 32'(busy), 32'd0);

        // --- read 0x3C after repeated START, NACK the byte ---
        issue(OP_START, 8'h00, 1'b0, lat);
        issue(OP_WRITE, 8'h01, 1'b0, lat);
        check("rd_addr_ack", 32'(ack_out), 32'd0);
        r0 = n_start;
        issue(OP_START, 8'h00, 1'b0, lat);
        check("rstart_lat",  lat,          4 * Q + 1);
        check("rstart_cond", n_start - r0, 32'd1);
        check("rstart_busy", 32'(busy),    32'd1);
        issue(OP_READ, 8'h00, 1'b1, lat);
        check("rd_lat",      lat,          36 * Q + 1);
        check("rd_data",     32'(rx_data), 32'h3C);
        check("rd_bus_bits", 32'(s_mon),   32'h3C);
        check("rd_nack",     32'(s_mack),  32'd1);
        check("rd_ack_out",  32'(ack_out), 32'd0);
        issue(OP_STOP, 8'h00, 1'b0, lat);
        check("rd_stop_busy", 32'(busy), 32'd0);

        // --- reset in the middle of bit 4 of a write ---
        issue(OP_START, 8'h00, 1'b0, lat);
        @(posedge clk); #1;
        tx_data = 8'hFF; cmd_write = 1'b1;
        @(posedge clk); #1;
        cmd_write = 1'b0;
        repeat (16 * Q + 4) @(posedge clk);
        #1;
        check("mid_scl_low", 32'(scl), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_scl",   32'(scl),     32'd1);
        check("mid_rst_sda",   32'(sda_bus), 32'd1);
        check("mid_rst_ready", 32'(ready),   32'd1);
        check("mid_rst_busy",  32'(busy),    32'd0);
        check("mid_rst_done",  32'(done),    32'd0);
        reset = 1'b0;
        dseen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dseen = 1'b1;
        end
        check("mid_rst_no_done", 32'(dseen), 32'd0);
        r0 = n_start;
        issue(OP_START, 8'h00, 1'b0, lat);
        check("post_rst_start_lat",  lat,          4 * Q + 1);
        check("post_rst_start_cond", n_start - r0, 32'd1);
        check("post_rst_busy",       32'(busy),    32'd1);
        issue(OP_WRITE, 8'h00, 1'b0, lat);
        check("post_rst_wr_ack", 32'(ack_out), 32'd0);
        issue(OP_STOP, 8'h00, 1'b0, lat);
        check("post_rst_stop_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master.md
# i2c_master

Single-master I2C bus controller that generates SCL and executes byte-level commands (START / repeated START, WRITE byte, READ byte, STOP) issued by a local controller. It sits between a CPU-side register or FSM front end and the shared SDA/SCL lines. It talks to the team's I2C slave blocks, which expect an address byte {addr[6:0], r/w}, then a word-address byte, then data bytes.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SCL_FREQ, 100_000, SCL frequency in Hz. Quarter period Q = CLK_FREQ/(4*SCL_FREQ) clocks (default 250). Q ≥ 2 is required.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cmd_start  input  1  pulse: issue START, or repeated START if the bus is already owned.
- cmd_write  input  1  pulse: shift out tx_data, then sample the slave ACK.
- cmd_read  input  1  pulse: shift in one byte, then drive ack_in.
- cmd_stop  input  1  pulse: issue STOP and release the bus.
- tx_data  input  8  byte to send, MSB first. Latched when cmd_write is accepted.
- ack_in  input  1  ACK bit to send after a read: 0 = ACK, 1 = NACK (last byte). Latched when cmd_read is accepted.
- rx_data  output  8  last byte read. Updated on the done cycle of a read.
- ack_out  output  1  ACK sampled from the slave on the last write: 0 = ACK.
- ready  output  1  high when a command can be accepted.
- done  output  1  one-cycle pulse when a command completes.
- busy  output  1  high from START completion until STOP completion (bus owned).
- scl  output  1  I2C clock, push-pull, high when idle.
- sda  inout  1  open-drain: driven 0 or high-Z only; never driven 1.

## Operation
- Command acceptance: a command is accepted on a cycle with ready=1 and the command pulse high. If several pulses are high, priority is start > stop > write > read; the others are dropped. Pulses while ready=0 are ignored.
- In IDLE (busy=0) only cmd_start is accepted. cmd_write, cmd_read and cmd_stop are ignored, and ready stays 1 with no done pulse.
- States:
  - IDLE: scl=1, sda released.
  - HOLD: bus owned, scl=0, sda held at its last value, waiting for a command.
  - START
  - RSTART
  - WBIT
  - WACK
  - RBIT
  - RACK
  - STOP
- Every bus phase lasts exactly Q clocks. A quarter counter (0..Q-1) advances the phase.
- START from IDLE: 4 phases.
  - P0: sda released, scl=1.
  - P1: sda=0, scl=1.
  - P2: sda=0, scl=1.
  - P3: scl=0.
  - Then HOLD, busy=1.
- RSTART from HOLD: 4 phases.
  - P0: scl=0, sda released.
  - P1: scl=1.
  - P2: sda=0, scl=1.
  - P3: scl=0.
  - Then HOLD.
- Bit slot (write, read and ACK bits), 4 phases.
  - P0: scl=0, sda updated.
  - P1: scl=1.
  - P2: scl=1.
  - P3: scl=0.
  - Sampling (read bits, slave ACK) occurs on the last clock of P1, which is mid-high.
- SDA changes only while scl=0, except in START, RSTART and STOP.
- WRITE: 8 bit slots MSB first (bit=0 → drive low, bit=1 → release), then a WACK slot with sda released. The sampled bit goes to ack_out. Then HOLD. A NACK does not abort; the controller decides.
- READ: 8 slots with sda released, sampled bits shifted in MSB first. Then an RACK slot driving the latched ack_in (0 → low, 1 → release). Then HOLD.
- STOP: 4 phases.
  - P0: scl=0, sda=0.
  - P1: scl=1, sda=0.
  - P2: scl=1, sda released (rising SDA while SCL is high).
  - P3: scl=1, sda released.
  - Then IDLE, busy=0.
- Reset (any cycle, including mid-byte): on the next edge state=IDLE, scl=1, sda released, ready=1, busy=0, done=0, ack_out=0, rx_data=0. No STOP is generated and no done pulse is produced.

## Timing
- ready falls the cycle after acceptance. done=1 and ready=1 occur on the same cycle, the first cycle back in HOLD/IDLE.
- Latency from the acceptance edge to done:
  - START, RSTART, STOP: 4Q+1 clocks.
  - WRITE, READ: 36Q+1 clocks (9 slots).
- A new command may be accepted on the done cycle itself. The bus then stays in HOLD with scl=0 between commands.
- rx_data and ack_out are stable from done until the next read or write completes.
- Bit counter 0..7 with no wrap. The quarter counter is sized ceil(log2(Q)) and resets to 0 on each phase change.

## Test plan
- Reset: assert reset for 3 cycles → scl=1, sda=Z, ready=1, busy=0, done=0, rx_data=0x00; cmd_write pulses in IDLE → no done, no scl activity.
- With Q=10: cmd_start, then cmd_write 0x00 to a slave model at address 0 → sda falls while scl=1; exactly 9 scl rising edges; done 361 clocks after acceptance; ack_out=0.
- Full write: START, 0x00, 0x01, 0xA5, STOP → slave register 1 = 0xA5; sda rises while scl=1 at STOP; busy=0 after the STOP done.
- Absent device: START, write 0x50 (sda only pulled up) → ack_out=1, busy stays 1; a following cmd_stop completes normally.
- Read: START, write 0x01, RSTART, read with ack_in=1 while the model drives 0x3C → rx_data=0x3C; master sda=Z through all 9 read slots; ack_out from the preceding write=0.
- Reset during bit 4 of a write → next cycle scl=1, sda=Z, ready=1, busy=0, no done; a subsequent START executes normally.
